// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
//   Frequency-sweep sequencer for an NCO. Accepts a sweep configuration
//   through a valid/ready handshake, then steps the NCO frequency control
//   word from a start value towards a stop value. Each word is held for
//   (dwell + 1) cycles. The sweep either repeats or ends with a done pulse.
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-high reset
//   cfg_valid  in   configuration offer
//   cfg_ready  out  high while IDLE; a configuration is accepted on valid & ready
//   cfg_start  in   first control word
//   cfg_stop   in   highest permitted control word
//   cfg_step   in   increment between words
//   cfg_dwell  in   hold cycles per word, minus one
//   cfg_loop   in   1 = restart at cfg_start after the last step
//   start      in   begin a sweep (IDLE only)
//   abort      in   terminate a running sweep, highest priority in RUN
//   ctrl       out  registered NCO frequency control word (0 when IDLE)
//   nco_reset  out  registered one-cycle pulse on sweep entry
//   busy       out  registered, high while RUN
//   done       out  registered one-cycle pulse on natural completion
module nco_sweep_ctrl #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [31:0]        cfg_start,
  input  logic [31:0]        cfg_stop,
  input  logic [31:0]        cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic               start,
  input  logic               abort,
  output logic [31:0]        ctrl,
  output logic               nco_reset,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state, w_state;
  logic                 r_cfg_valid, w_cfg_valid;
  logic [31:0]          r_start, w_start;
  logic [31:0]          r_stop, w_stop;
  logic [31:0]          r_step, w_step;
  logic [DWELL_W-1:0]   r_dwell, w_dwell;
  logic                 r_loop, w_loop;
  logic [DWELL_W-1:0]   r_cnt, w_cnt;
  logic [31:0]          r_ctrl, w_ctrl;
  logic                 r_nco_reset, w_nco_reset;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 w_hs;
  logic [32:0]          w_next;
  logic                 w_step_ok;

  assign cfg_ready = (r_state == IDLE);
  assign ctrl      = r_ctrl;
  assign nco_reset = r_nco_reset;
  assign busy      = r_busy;
  assign done      = r_done;

  assign w_hs   = cfg_valid & cfg_ready;
  // 33-bit sum so a carry out of the 32-bit word is visible and ends the sweep
  assign w_next = {1'b0, r_ctrl} + {1'b0, r_step};
  assign w_step_ok = (r_step != '0) && !w_next[32] && (w_next[31:0] <= r_stop);

  always_comb begin
    w_state     = r_state;
    w_cfg_valid = r_cfg_valid | w_hs;
    w_start     = r_start;
    w_stop      = r_stop;
    w_step      = r_step;
    w_dwell     = r_dwell;
    w_loop      = r_loop;
    w_cnt       = r_cnt;
    w_ctrl      = r_ctrl;
    w_nco_reset = 1'b0;
    w_done      = 1'b0;

    if (w_hs) begin
      w_start = cfg_start;
      w_stop  = cfg_stop;
      w_step  = cfg_step;
      w_dwell = cfg_dwell;
      w_loop  = cfg_loop;
    end

    unique case (r_state)
      IDLE: begin
        w_ctrl = '0;
        // A same-cycle handshake feeds the new fields straight into this sweep
        if (start && (r_cfg_valid || w_hs)) begin
          w_state     = RUN;
          w_ctrl      = w_hs ? cfg_start : r_start;
          w_cnt       = w_hs ? cfg_dwell : r_dwell;
          w_nco_reset = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          w_state = IDLE;
          w_ctrl  = '0;
          w_cnt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt = r_cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
        end else if (w_step_ok) begin
          w_ctrl = w_next[31:0];
          w_cnt  = r_dwell;
        end else if (r_loop) begin
          w_ctrl = r_start;
          w_cnt  = r_dwell;
        end else begin
          w_state = IDLE;
          w_ctrl  = '0;
          w_cnt   = '0;
          w_done  = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase

    w_busy = (w_state == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cfg_valid <= 1'b0;
      r_start     <= '0;
      r_stop      <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_loop      <= 1'b0;
      r_cnt       <= '0;
      r_ctrl      <= '0;
      r_nco_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cfg_valid <= w_cfg_valid;
      r_start     <= w_start;
      r_stop      <= w_stop;
      r_step      <= w_step;
      r_dwell     <= w_dwell;
      r_loop      <= w_loop;
      r_cnt       <= w_cnt;
      r_ctrl      <= w_ctrl;
      r_nco_reset <= w_nco_reset;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 Parameter: DWELL_W, default 16, width of the dwell counter and the cfg_dwell field.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 cfg_valid  input  1  configuration offer; accepted when cfg_valid & cfg_ready are both high at a clk edge.
REQ-005 cfg_ready  output  1  high exactly while state is IDLE.
REQ-006 cfg_start  input  32  first frequency control word, unsigned.
REQ-007 cfg_stop  input  32  highest permitted frequency control word, unsigned.
REQ-008 cfg_step  input  32  increment between steps, unsigned.
REQ-009 cfg_dwell  input  DWELL_W  number of cycles each word is held, minus one.
REQ-010 cfg_loop  input  1  1 = restart at cfg_start after the last step; 0 = single sweep.
REQ-011 start  input  1  begin a sweep; sampled only in IDLE.
REQ-012 abort  input  1  terminate a running sweep.
REQ-013 ctrl  output  32  registered frequency control word driven to the NCO ctrl input.
REQ-014 nco_reset  output  1  registered one-cycle pulse that zeroes the NCO phase accumulator.
REQ-015 busy  output  1  registered; high while state is RUN.
REQ-016 done  output  1  registered one-cycle pulse on natural sweep completion.

Function
REQ-017 The FSM shall have two states, IDLE and RUN; a config_valid flag shall be set by the first accepted configuration and cleared only by reset.
REQ-018 On a handshake, the block shall copy all cfg_* fields into internal shadow registers; cfg_valid shall be ignored in RUN.
REQ-019 A start in IDLE with config_valid=0 and no same-cycle handshake shall be ignored.
REQ-020 start in IDLE with config_valid=1, or with a same-cycle handshake, shall enter RUN; a same-cycle handshake shall supply the new values to this sweep.
REQ-021 On RUN entry, the registered outputs shall take: ctrl=start value, nco_reset=1 for that cycle only, busy=1, dwell counter=dwell value.
REQ-022 In RUN with counter != 0, the counter shall decrement and ctrl shall hold, so each word is held exactly dwell+1 cycles.
REQ-023 In RUN with counter == 0, the next word shall be computed as 33-bit next = ctrl + step.
REQ-024 If step != 0, next[32]==0 and next[31:0] <= stop, then ctrl=next[31:0] and the counter shall reload.
REQ-025 Otherwise (step==0, carry out, or next > stop), the end-of-sweep action shall apply: with loop=1, ctrl=start and the counter reloads, with no nco_reset pulse; with loop=0, the block goes to IDLE with ctrl=0, busy=0 and done=1 for one cycle.
REQ-026 start > stop shall be legal: the start value is output for one dwell period, then the end-of-sweep action applies.
REQ-027 abort in RUN shall have priority over all other events: next cycle IDLE, ctrl=0, busy=0, no done pulse, no nco_reset pulse.
REQ-028 abort in IDLE shall be ignored; start in RUN shall be ignored.
REQ-029 ctrl shall never wrap past 2^32; a carry out shall always be treated as end of sweep.
REQ-030 In IDLE, ctrl shall be 0, and nco_reset and done shall be 0 except for the done pulse defined in REQ-025.

Reset
REQ-031 Asserting reset shall immediately force: state IDLE, ctrl=0, nco_reset=0, busy=0, done=0, config_valid=0, counter=0, shadow registers=0; cfg_ready shall then read 1.
REQ-032 Reset asserted mid-sweep shall abandon the sweep with no done pulse; after release, start is ignored until a new configuration is accepted.

Verification
REQ-033 Reset release -> ctrl=0, busy=0, done=0, nco_reset=0, cfg_ready=1; start alone -> no response.
REQ-034 start=0x100, stop=0x300, step=0x100, dwell=2, loop=0, then start -> ctrl=0x100 x3, 0x200 x3, 0x300 x3 cycles, with nco_reset high only in the first cycle; busy high for 9 cycles; done pulse in the cycle ctrl returns to 0.
REQ-035 start=0xFFFFFF00, step=0x200, stop=0xFFFFFFFF, dwell=0, loop=0 -> ctrl=0xFFFFFF00 for 1 cycle, then done; no 0x100 value ever appears.
REQ-036 start=0x10, stop=0x20, step=0x10, dwell=0, loop=1 -> ctrl sequence 0x10, 0x20, 0x10, 0x20, ... with a single nco_reset pulse; abort -> next cycle ctrl=0, busy=0, done=0.
REQ-037 cfg_valid with new values while busy -> cfg_ready=0 and the running sweep is unchanged; handshake plus start in the same IDLE cycle -> sweep uses the new cfg_start.
REQ-038 Asynchronous reset pulse between clock edges mid-sweep -> outputs clear before the next edge; no done pulse; a following start is ignored.
